// File: rtl/bf16_class_arb_if.sv
// Bus between parallel bf16 producers, the shared classifier and its single consumer.
// The master side drives requests, downstream ready and counter clear; the slave side is the classifier.
interface bf16_class_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int NUM_WIDTH  = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int SIG_WIDTH  = 7,
  parameter int FLAG_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]           i_valid;
  logic [NUM_REQ*NUM_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]           o_ready;
  logic                         o_valid;
  logic                         i_ready;
  logic [ID_WIDTH-1:0]          o_id;
  logic [FLAG_WIDTH-1:0]        o_flag;
  logic [SIG_WIDTH-1:0]         o_sig;
  logic signed [EXP_WIDTH-1:0]  o_exp;
  logic                         o_sign;
  logic                         i_cnt_clr;
  logic [CNT_WIDTH-1:0]         o_nan_cnt;
  logic [CNT_WIDTH-1:0]         o_zero_cnt;
  logic [CNT_WIDTH-1:0]         o_inf_cnt;
  logic [CNT_WIDTH-1:0]         o_norm_cnt;

  modport master (
    output i_valid, i_data, i_ready, i_cnt_clr,
    input  o_ready, o_valid, o_id, o_flag, o_sig, o_exp, o_sign,
           o_nan_cnt, o_zero_cnt, o_inf_cnt, o_norm_cnt
  );

  modport slave (
    input  i_valid, i_data, i_ready, i_cnt_clr,
    output o_ready, o_valid, o_id, o_flag, o_sig, o_exp, o_sign,
           o_nan_cnt, o_zero_cnt, o_inf_cnt, o_norm_cnt
  );
endinterface

// File: rtl/bf16_class_arb.sv
// Round-robin shared bf16 classifier with a one-entry registered output stage
// and saturating per-class delivery counters.
module bf16_class_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int NUM_WIDTH  = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int SIG_WIDTH  = 7,
  parameter int FLAG_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  bf16_class_arb_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [FLAG_WIDTH-1:0] flag_q;
  logic [SIG_WIDTH-1:0]  sig_q;
  logic [EXP_WIDTH-1:0]  exp_q;
  logic                  sign_q;
  logic [CNT_WIDTH-1:0]  cnt_q [FLAG_WIDTH];

  logic                  accept;
  logic                  found;
  logic                  handshake;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [NUM_WIDTH-1:0]  word;
  int                    idx;

  logic [EXP_WIDTH-1:0]  exp_d;
  logic [SIG_WIDTH-1:0]  sig_d;
  logic                  exp_ones, exp_zero, sig_zero;
  logic [FLAG_WIDTH-1:0] flag_d;

  assign accept    = (state_q == EMPTY) || bus.i_ready;
  assign handshake = (state_q == FULL) && bus.i_ready;

  // Search from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    found  = 1'b0;
    gnt_id = ptr_q;
    word   = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.i_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_WIDTH'(idx);
        word   = bus.i_data[idx*NUM_WIDTH +: NUM_WIDTH];
      end
    end
  end

  always_comb begin
    bus.o_ready = '0;
    for (int k = 0; k < NUM_REQ; k++)
      bus.o_ready[k] = !i_rst && accept && found && (gnt_id == ID_WIDTH'(k));
  end

  assign exp_d    = word[NUM_WIDTH-2 -: EXP_WIDTH];
  assign sig_d    = word[SIG_WIDTH-1:0];
  assign exp_ones = &exp_d;
  assign exp_zero = ~|exp_d;
  assign sig_zero = ~|sig_d;
  // Flag order is {nan, zero, inf, norm}; subnormals fall through to norm.
  assign flag_d   = {exp_ones & ~sig_zero,
                     exp_zero & sig_zero,
                     exp_ones & sig_zero,
                     ~((exp_ones) | (exp_zero & sig_zero))};

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      flag_q  <= '0;
      sig_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      // NOTE: this small counter array is software-visible state, so it is reset like any register.
      for (int c = 0; c < FLAG_WIDTH; c++) cnt_q[c] <= '0;
    end else begin
      if (accept) begin
        if (found) begin
          state_q <= FULL;
          ptr_q   <= ID_WIDTH'((int'(gnt_id) + 1) % NUM_REQ);
          id_q    <= gnt_id;
          flag_q  <= flag_d;
          sig_q   <= sig_d;
          exp_q   <= exp_d;
          sign_q  <= word[NUM_WIDTH-1];
        end else begin
          state_q <= EMPTY;
        end
      end
      for (int c = 0; c < FLAG_WIDTH; c++) begin
        if (bus.i_cnt_clr)
          cnt_q[c] <= '0;
        else if (handshake && flag_q[c] && (cnt_q[c] != '1))
          cnt_q[c] <= cnt_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.o_valid    = (state_q == FULL);
  assign bus.o_id       = id_q;
  assign bus.o_flag     = flag_q;
  assign bus.o_sig      = sig_q;
  assign bus.o_exp      = exp_q;
  assign bus.o_sign     = sign_q;
  assign bus.o_nan_cnt  = cnt_q[3];
  assign bus.o_zero_cnt = cnt_q[2];
  assign bus.o_inf_cnt  = cnt_q[1];
  assign bus.o_norm_cnt = cnt_q[0];

endmodule

// File: doc/bf16_class_arb.md
Name: bf16_class_arb

Overview:
Shares one bf16 classification stage between NUM_REQ requesters using round-robin arbitration. Each accepted word is decoded into sign, exponent, significand and class flag, then held in a registered output stage with a valid/ready handshake and requester ID. The block sits between parallel bf16 producers and a single downstream consumer. It also keeps saturating per-class event counters that software can clear.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ID_WIDTH, 2, requester ID width (= clog2(NUM_REQ), set by instantiator)
NUM_WIDTH, 16, bf16 word width
EXP_WIDTH, 8, exponent field width
SIG_WIDTH, 7, significand field width
FLAG_WIDTH, 4, class flag width
CNT_WIDTH, 16, per-class counter width

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  NUM_REQ  per-requester word valid
i_data  input  NUM_REQ*NUM_WIDTH  requester k word at [k*NUM_WIDTH +: NUM_WIDTH]
o_ready  output  NUM_REQ  one-hot accept to the granted requester (combinational)
o_valid  output  1  output register holds a result
i_ready  input  1  downstream accepts the result
o_id  output  ID_WIDTH  requester index of the result
o_flag  output  FLAG_WIDTH  {nan, zero, inf, norm}
o_sig  output  SIG_WIDTH  significand field
o_exp  output  EXP_WIDTH  exponent field (signed port, raw bits)
o_sign  output  1  sign bit
i_cnt_clr  input  1  clear all class counters
o_nan_cnt, o_zero_cnt, o_inf_cnt, o_norm_cnt  output  CNT_WIDTH each  delivered-result counts per class

Behaviour:
- Reset (i_clk edge with i_rst=1):
  - o_valid=0; o_id, o_flag, o_sig, o_exp, o_sign = 0.
  - All counters = 0.
  - RR pointer = 0.
  - o_ready = 0 during reset.
- Classification, applied to the granted word:
  - sign = bit 15; exp = bits 14:7; sig = bits 6:0.
  - nan = exp all-ones and sig != 0.
  - inf = exp all-ones and sig == 0.
  - zero = exp == 0 and sig == 0 (either sign).
  - norm = none of the above; subnormals therefore classify as norm.
  - Exactly one flag bit is set.
- Output stage is a 2-state FSM:
  - EMPTY (o_valid=0). FULL (o_valid=1).
  - accept = (EMPTY) or (FULL and i_ready).
  - EMPTY: if any i_valid, grant and go FULL; otherwise stay EMPTY.
  - FULL with i_ready: if any i_valid, reload with a new grant and stay FULL (back-to-back, 1 result/cycle); otherwise go EMPTY.
  - FULL without i_ready: hold every output stable; o_ready = 0.
- Arbitration:
  - Search starts at the pointer: ptr, ptr+1, ... mod NUM_REQ. The first asserted i_valid wins.
  - o_ready[k] = accept and grant[k]. At most one bit is high.
  - On a grant to k, the pointer becomes (k+1) mod NUM_REQ. Without a grant, the pointer is unchanged.
  - Requesters must hold i_valid and i_data until they see their o_ready.
- Latency: a word granted at edge N appears at the outputs after edge N, i.e. one cycle.
- Counters:
  - The counter selected by o_flag increments on an output handshake (o_valid and i_ready).
  - Each counter saturates at all-ones and does not wrap.
  - i_cnt_clr sets all counters to 0 and takes priority over a same-cycle increment; the result is 0.
  - Clearing does not affect the datapath.
- Reset mid-operation: a held result is discarded, o_valid=0 the next cycle, no counter increments, and the pointer returns to 0.
- No combinational path from i_ready to o_valid. o_ready depends on i_ready and i_valid only.

Test Plan:
- Single requester 0, i_data=0x3F80, i_ready=1:
  - o_ready[0]=1 in the grant cycle.
  - Next cycle: o_valid=1, o_id=0, o_flag=4'b0001, o_exp=0x7F, o_sig=0, o_sign=0.
  - o_norm_cnt=1 after the handshake.
- Class coverage on requester 2:
  - 0x7FC0 -> flag 1000.
  - 0x7F80 -> 0010.
  - 0x8000 -> 0100 with o_sign=1.
  - 0x0001 -> 0001 (subnormal is norm).
  - Counters end at nan=1, inf=1, zero=1, norm=1.
- All 4 requesters valid continuously, i_ready=1:
  - o_id sequence is 0,1,2,3,0,1 with o_valid high every cycle.
  - Each o_ready bit is high 1 cycle in 4.
- Backpressure: result held with i_ready=0 for 3 cycles while requesters 1 and 3 are valid:
  - Outputs are stable and o_ready=0.
  - When i_ready rises, the next result comes from requester 1, then requester 3.
- Set o_nan_cnt to all-ones minus 1 via a CNT_WIDTH=4 build, then drive 3 NaN words:
  - Counter reads 15 and stays 15.
  - i_cnt_clr asserted in the same cycle as a NaN handshake -> counter 0.
- Assert i_rst while FULL with i_ready=0:
  - Next cycle o_valid=0, all counters 0.
  - The first grant afterwards goes to the lowest-index valid requester.
